ysyx_2022040010_ifu: RTL
========================

YSYX_2022040010_IFU -- requirements
Module: ysyx_2022040010_ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries (fixed at 2; other values unsupported).
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_req_addr  out  64  fetch address, bits[1:0] always 0.
REQ-008 imem_rsp_valid  in  1  response data valid, one per accepted request, any latency >=1 cycle.
REQ-009 imem_rsp_data  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  single-cycle PC redirect (branch/jump target) from later stages.
REQ-011 redirect_pc  in  64  redirect target.
REQ-012 id_valid_o  out  1  instruction/PC pair valid to decode.
REQ-013 id_ready_i  in  1  decode accepts pair.
REQ-014 pc_o  out  64  PC of head instruction, drives decode pc_i.
REQ-015 inst_o  out  32  head instruction, drives decode inst_i.

Function
REQ-016 FSM states: REQ, WAIT, DISCARD; at most one request outstanding at any time.
REQ-017 REQ: imem_req_valid=1 iff buffer count<2; imem_req_addr=fetch_pc.
REQ-018 REQ and imem_req_valid&&imem_req_ready: latch req_pc=fetch_pc, fetch_pc<=fetch_pc+4 (64-bit wrap modulo 2^64), go WAIT.
REQ-019 WAIT: imem_req_valid=0; on imem_rsp_valid push {req_pc, imem_rsp_data} into buffer tail, go REQ.
REQ-020 REQ ignores imem_rsp_valid (no push).
REQ-021 DISCARD: imem_req_valid=0; on imem_rsp_valid drop data (no push), go REQ.
REQ-022 Buffer: 2-entry FIFO; id_valid_o=(count!=0); pc_o/inst_o = head entry, held stable while id_valid_o&&!id_ready_i.
REQ-023 Pop when id_valid_o&&id_ready_i; simultaneous push and pop allowed at any count, count unchanged, order preserved.
REQ-024 Push never occurs when count==2 (guaranteed by REQ-017); entries fetched in PC order.
REQ-025 pc_o/inst_o = 0 when count==0.
REQ-026 redirect_valid has highest priority: buffer flushed (count<=0, no pop counted) and fetch_pc<={redirect_pc[63:2],2'b00} next cycle.
REQ-027 Redirect in WAIT without same-cycle rsp, or in REQ with same-cycle request handshake: next state DISCARD.
REQ-028 Redirect in WAIT with same-cycle imem_rsp_valid: response dropped, next state REQ.
REQ-029 Redirect in REQ without handshake, or in DISCARD: DISCARD stays DISCARD until its response; REQ stays REQ.
REQ-030 Redirect does not advance fetch_pc by 4; first request after redirect uses the aligned target.
REQ-031 Fetch latency: request accepted cycle N, response cycle M>N -> id_valid_o=1 from cycle M+1.

Reset
REQ-032 While rst=1 at a clock edge: state<=REQ, fetch_pc<=RESET_PC, req_pc<=0, count<=0, buffer entries<=0.
REQ-033 Outputs after reset: imem_req_valid=1, imem_req_addr=RESET_PC, id_valid_o=0, pc_o=0, inst_o=0.
REQ-034 Reset mid-operation: in-flight request abandoned; a late response arriving in REQ is ignored (REQ-020).

Verification
REQ-035 Reset, req_ready=1, rsp 1 cycle later with 32'h00100093, id_ready=1 -> id_valid_o with pc_o=64'h8000_0000, inst_o=32'h00100093; next request addr 64'h8000_0004.
REQ-036 id_ready=0 for 10 cycles, memory always ready -> exactly 2 entries (PCs 8000_0000, 8000_0004), request stalls with count==2, head stable; id_ready=1 -> resumes at 8000_0008.
REQ-037 Request at 8000_0010 accepted, redirect_pc=64'h8000_0102 next cycle before rsp -> response dropped, count=0, next request addr 8000_0100.
REQ-038 Redirect coincident with request handshake and with response (separate runs) -> no stale instruction ever on id_valid_o; only target-PC fetches delivered.
REQ-039 rst asserted in WAIT, response arrives cycle after reset release -> response ignored, first delivered pc_o=RESET_PC.
REQ-040 fetch_pc=64'hFFFF_FFFF_FFFF_FFFC via redirect -> next request addr 64'h0 after handshake.

Source files
------------

// File: rtl/ysyx_2022040010_ifu.sv
// Instruction fetch unit: issues one fetch at a time to instruction memory,
// buffers up to two {pc, inst} pairs and hands them to decode in PC order.
// A redirect from a later stage flushes the buffer and restarts fetch at the
// target; any response still in flight for the old path is discarded.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req_valid/ready/addr fetch request channel (word aligned address)
//   imem_rsp_valid/data       fetch response, one per accepted request
//   redirect_valid/pc         single-cycle PC redirect
//   id_valid_o/id_ready_i     handshake with decode
//   pc_o/inst_o               head pair of the buffer (zero when empty)
module ysyx_2022040010_ifu #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [63:0] pc_o,
    output logic [31:0] inst_o
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [63:0]        r_fetch_pc;
    logic [63:0]        r_req_pc;
    logic [CNT_W-1:0]   r_count;
    logic [63:0]        r_pc0;
    logic [63:0]        r_pc1;
    logic [31:0]        r_inst0;
    logic [31:0]        r_inst1;

    logic               w_full;
    logic               w_hs;
    logic               w_push;
    logic               w_pop;
    logic [63:0]        w_redirect_tgt;

    assign w_full         = (r_count == CNT_W'(BUF_DEPTH));
    assign w_hs           = imem_req_valid && imem_req_ready;
    // A response that coincides with a redirect belongs to the old path.
    assign w_push         = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_pop          = id_valid_o && id_ready_i && !redirect_valid;
    assign w_redirect_tgt = redirect_pc & ~64'h3;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_REQ;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; redirects send an outstanding request to DISCARD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_hs) w_state_nxt = redirect_valid ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid)      w_state_nxt = S_REQ;
                else if (redirect_valid) w_state_nxt = S_DISCARD;
            end
            S_DISCARD: begin
                if (imem_rsp_valid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // FSM outputs: request only from REQ and only while the buffer has room.
    always_comb begin
        imem_req_valid = 1'b0;
        if ((r_state == S_REQ) && !w_full) imem_req_valid = 1'b1;
    end

    assign imem_req_addr = r_fetch_pc;

    // Fetch PC and the PC of the request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
        end else begin
            if (w_hs) r_req_pc <= r_fetch_pc;
            if (redirect_valid) r_fetch_pc <= w_redirect_tgt;
            else if (w_hs)      r_fetch_pc <= r_fetch_pc + 64'd4;
        end
    end

    // Two-entry FIFO kept as head (entry 0) and tail (entry 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_pc0   <= '0;
            r_pc1   <= '0;
            r_inst0 <= '0;
            r_inst1 <= '0;
        end else if (redirect_valid) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0   <= r_req_pc;
                        r_inst0 <= imem_rsp_data;
                    end else begin
                        r_pc1   <= r_req_pc;
                        r_inst1 <= imem_rsp_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_pc0   <= r_pc1;
                    r_inst0 <= r_inst1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_pc0   <= r_req_pc;
                        r_inst0 <= imem_rsp_data;
                    end else begin
                        r_pc0   <= r_pc1;
                        r_inst0 <= r_inst1;
                        r_pc1   <= r_req_pc;
                        r_inst1 <= imem_rsp_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign id_valid_o = (r_count != 2'd0);
    assign pc_o       = id_valid_o ? r_pc0   : 64'd0;
    assign inst_o     = id_valid_o ? r_inst0 : 32'd0;

endmodule
